// File: rtl/ex_issue_stage.sv
// ex_issue_stage: ID/EX pipeline register that decodes opcode/funct3/funct7[5]
// into the ALU control code and operand select, then holds the instruction
// for the EX-stage ALU behind a single-entry valid/ready handshake.
module ex_issue_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [4:0]       rd,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             ALUSrc,
  output logic [3:0]       ALUcontrol,
  output logic [XLEN-1:0]  data1,
  output logic [XLEN-1:0]  read2,
  output logic [XLEN-1:0]  imme,
  output logic [4:0]       rd_out,
  output logic             is_branch,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_NEQ = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SGE = 4'b1000;
  localparam logic [3:0] ALU_XOR = 4'b1001;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  logic [3:0] decCtrl;
  logic       decSrc;
  logic       decBranch;
  logic       decIllegal;
  logic       accept;
  logic       consume;

  // The register can take a new instruction when empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // Decode the incoming instruction; anything unlisted falls through as
  // illegal with the "ALU returns 0" code so the trap logic can catch it.
  always_comb begin
    decCtrl    = ALU_BAD;
    decSrc     = 1'b0;
    decBranch  = 1'b0;
    decIllegal = 1'b1;
    unique case (opcode)
      OP_R, OP_I: begin
        decIllegal = 1'b0;
        case (funct3)
          3'b000:  decCtrl = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  begin
            decCtrl = ALU_SLL;
            if (opcode == OP_I && funct7_5) decIllegal = 1'b1;
          end
          3'b010:  decCtrl = ALU_SLT;
          3'b100:  decCtrl = ALU_XOR;
          3'b110:  decCtrl = ALU_OR;
          3'b111:  decCtrl = ALU_AND;
          default: decIllegal = 1'b1;
        endcase
        if (decIllegal) begin
          decCtrl = ALU_BAD;
        end else begin
          decSrc = (opcode == OP_I);
        end
      end
      OP_LOAD, OP_STORE: begin
        decCtrl    = ALU_ADD;
        decSrc     = 1'b1;
        decIllegal = 1'b0;
      end
      OP_BRANCH: begin
        decIllegal = 1'b0;
        decBranch  = 1'b1;
        case (funct3)
          3'b000:  decCtrl = ALU_SUB;
          3'b001:  decCtrl = ALU_NEQ;
          3'b110:  decCtrl = ALU_SGE;
          3'b111:  decCtrl = ALU_SLT;
          default: begin
            decCtrl    = ALU_BAD;
            decBranch  = 1'b0;
            decIllegal = 1'b1;
          end
        endcase
      end
      default: begin
        decCtrl    = ALU_BAD;
        decIllegal = 1'b1;
      end
    endcase
  end

  // Pipeline register: reset beats flush, flush beats accept/hold, and the
  // issue counter only advances on a real hand-off to EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      ALUSrc      <= 1'b0;
      ALUcontrol  <= 4'b0000;
      data1       <= '0;
      read2       <= '0;
      imme        <= '0;
      rd_out      <= 5'd0;
      is_branch   <= 1'b0;
      illegal     <= 1'b0;
      issue_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (consume) begin
        issue_count <= issue_count + CNT_W'(1);
      end
      if (accept) begin
        out_valid  <= 1'b1;
        ALUSrc     <= decSrc;
        ALUcontrol <= decCtrl;
        data1      <= rs1_data;
        read2      <= rs2_data;
        imme       <= imm;
        rd_out     <= rd;
        is_branch  <= decBranch;
        illegal    <= decIllegal;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ex_issue_stage.md
Name: ex_issue_stage

Overview:
- ID/EX pipeline stage that drives the ALU's operand and control inputs.
- Decodes opcode/funct3/funct7[5] into the 4-bit ALU control code and the operand-select bit, then registers these together with the operands and destination register.
- Sits between decode and the EX-stage ALU, with a valid/ready handshake on both sides and a flush input for branch/jump recovery.
- Branch encodings are chosen so every supported branch is taken when the ALU's zero output is 1.

Parameters:
XLEN, 64, operand/immediate width
CNT_W, 32, width of the issued-instruction counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage can accept this cycle
opcode  input  7  instruction[6:0]
funct3  input  3  instruction[14:12]
funct7_5  input  1  instruction[30]
rs1_data  input  XLEN  source 1 value
rs2_data  input  XLEN  source 2 value
imm  input  XLEN  sign-extended immediate
rd  input  5  destination register
flush  input  1  kill the registered instruction and the one being accepted
out_ready  input  1  EX stage can consume
out_valid  output  1  registered instruction valid
ALUSrc  output  1  0 = read2, 1 = imme
ALUcontrol  output  4  ALU operation code
data1  output  XLEN  registered rs1_data
read2  output  XLEN  registered rs2_data
imme  output  XLEN  registered imm
rd_out  output  5  registered rd
is_branch  output  1  instruction is a conditional branch
illegal  output  1  unsupported encoding
issue_count  output  CNT_W  count of instructions handed to EX

Behaviour:
- Reset (synchronous, active-high): every output register cleared to 0, including out_valid, ALUcontrol, ALUSrc, data1, read2, imme, rd_out, is_branch, illegal and issue_count. in_ready is 1 in the first cycle after reset.
- in_ready = !out_valid || out_ready (combinational). This is a single-entry register with no skid buffer.
- Accept: in_valid && in_ready at a rising edge loads all registers; out_valid = 1 on the next cycle. Latency is 1 cycle.
- Hold: out_valid && !out_ready keeps every output stable and in_ready = 0.
- Consume: out_valid && out_ready with no new accept sets out_valid = 0.
- issue_count increments on each out_valid && out_ready && !flush cycle and wraps from 2^CNT_W-1 to 0.
- Flush has priority over accept and hold.
  - Flush sets out_valid = 0 next cycle and discards any simultaneous accept.
  - Data registers may retain their old values.
  - Flush during reset has no effect; reset wins.
- Decode, applied at accept:
  - R-type 0110011, ALUSrc = 0:
    - funct3 000: f7_5 = 0 gives 0010 ADD; f7_5 = 1 gives 0110 SUB.
    - 001 gives 0100 SLL; 010 gives 0111 SLT; 100 gives 1001 XOR; 110 gives 0001 OR; 111 gives 0000 AND.
  - I-ALU 0010011, ALUSrc = 1: same funct3 map with f7_5 ignored (000 is ADD), except funct3 = 001 with f7_5 = 1 is illegal.
  - Load 0000011 / store 0100011: ADD, ALUSrc = 1.
  - Branch 1100011, ALUSrc = 0, is_branch = 1:
    - 000 BEQ gives SUB (0110).
    - 001 BNE gives NEQ (0011); its result is 1 when equal, so zero = 1 means taken.
    - 110 BLTU gives SGE (1000).
    - 111 BGEU gives SLT (0111).
    - The ALU compares unsigned, so 100 BLT and 101 BGE are illegal.
  - Any other opcode/funct3: illegal = 1, ALUcontrol = 1111 (ALU returns 0), ALUSrc = 0, is_branch = 0. The instruction is still issued with out_valid = 1 so the trap logic sees it.
- Operands are registered unmodified; no sign or width changes. Unused outputs still carry the latched values (for example imme on R-type).

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0, in_ready = 1, issue_count = 0.
- R-type funct3 000, f7_5 = 1, rs1 = 0x10, rs2 = 0x3, out_ready = 1 -> next cycle out_valid = 1, ALUcontrol = 0110, ALUSrc = 0, data1 = 0x10, read2 = 0x3; issue_count = 1 the cycle after.
- BNE (opcode 1100011, funct3 001) then BLT (funct3 100) -> ALUcontrol = 0011 with is_branch = 1; then illegal = 1 with ALUcontrol = 1111.
- ADDI imm = 0xFFFFFFFFFFFFFFFF, out_ready = 0 for 3 cycles -> outputs stable, in_ready = 0, a new in_valid is not accepted; out_ready = 1 -> consumed, next instruction accepted in the same cycle.
- flush asserted in the same cycle as a valid accept while the register holds an instruction -> out_valid = 0 next cycle, issue_count unchanged.
- Drive 2^CNT_W consumes with CNT_W overridden to 4 (16 consumes) -> issue_count wraps from 15 to 0.
